// File: rtl/fnd_scan_controller.sv
// Four-digit multiplexed 7-segment (FND) scan controller: prescaled digit scan,
// frame-synchronous display loading, leading-zero blanking and per-digit blink.
module fnd_scan_controller #(
  parameter int unsigned SYS_CLK_HZ   = 100_000_000,
  parameter int unsigned SCAN_HZ      = 1_000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_bcd,
  input  logic        i_load,
  input  logic [3:0]  i_dp,
  input  logic [3:0]  i_blink_mask,
  input  logic        i_blank_lz,
  input  logic        i_enable,
  output logic [2:0]  o_digitSelect,
  output logic        o_en,
  output logic [3:0]  o_value,
  output logic        o_dp,
  output logic        o_load_ack
);

  localparam int unsigned DIV = SYS_CLK_HZ / SCAN_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BW  = $clog2(BLINK_FRAMES + 1);
  localparam logic [PW-1:0] PRE_LAST   = PW'(DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre_cnt;
  logic [1:0]    digit;
  logic [15:0]   staging;
  logic [15:0]   display;
  logic          pending;
  logic [BW-1:0] frame_cnt;
  logic          blink_hidden;

  logic          tick;
  logic          boundary;
  logic [1:0]    digit_next;
  logic [15:0]   staging_next;
  logic [15:0]   display_next;
  logic          pending_next;
  logic          ack_next;
  logic [BW-1:0] frame_cnt_next;
  logic          blink_hidden_next;
  logic [15:0]   upper;
  logic          leading_zero;
  logic          en_next;

  assign tick       = (pre_cnt == PRE_LAST);
  assign boundary   = tick && (digit == 2'd3);
  assign digit_next = digit + 2'd1;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    staging_next      = staging;
    display_next      = display;
    pending_next      = pending;
    ack_next          = 1'b0;
    frame_cnt_next    = frame_cnt;
    blink_hidden_next = blink_hidden;

    if (i_load) begin
      staging_next = i_bcd;
      pending_next = 1'b1;
    end

    if (boundary) begin
      // A load landing on the boundary itself bypasses staging entirely.
      if (i_load) begin
        display_next = i_bcd;
        pending_next = 1'b0;
        ack_next     = 1'b1;
      end else if (pending) begin
        display_next = staging;
        pending_next = 1'b0;
        ack_next     = 1'b1;
      end

      if (frame_cnt == BLINK_LAST) begin
        frame_cnt_next    = '0;
        blink_hidden_next = ~blink_hidden;
      end else begin
        frame_cnt_next = frame_cnt + BW'(1);
      end
    end
  end

  // Outputs describe the digit being entered, using post-edge display and blink state.
  assign upper        = display_next >> {digit_next, 2'b00};
  assign leading_zero = i_blank_lz && (digit_next != 2'd0) && (upper == 16'h0000);
  assign en_next      = i_enable && !leading_zero &&
                        !(i_blink_mask[digit_next] && blink_hidden_next);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pre_cnt       <= '0;
      digit         <= 2'd0;
      staging       <= 16'h0000;
      display       <= 16'h0000;
      pending       <= 1'b0;
      frame_cnt     <= '0;
      blink_hidden  <= 1'b0;
      o_digitSelect <= 3'd0;
      o_en          <= 1'b0;
      o_value       <= 4'd0;
      o_dp          <= 1'b0;
      o_load_ack    <= 1'b0;
    end else begin
      pre_cnt      <= tick ? '0 : pre_cnt + PW'(1);
      staging      <= staging_next;
      display      <= display_next;
      pending      <= pending_next;
      frame_cnt    <= frame_cnt_next;
      blink_hidden <= blink_hidden_next;
      o_load_ack   <= ack_next;
      if (tick) begin
        digit         <= digit_next;
        o_digitSelect <= {1'b0, digit_next};
        o_en          <= en_next;
        o_value       <= upper[3:0];
        o_dp          <= i_dp[digit_next] & en_next;
      end
    end
  end

endmodule
